// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the five-stage pipeline.
// Tracks the instructions in EX and MEM through two shadow slots, drives the
// registered EX operand selects, inserts load-use stalls, squashes wrong-path
// instructions on a taken branch/jump, and keeps saturating event counters.
//
//   state  | meaning
//   -------+----------------------------------------------------------------
//   RUN    | normal issue; EX branch outcome is honoured
//   SQUASH | EX holds the bubble just inserted; EX branch inputs are ignored
module pipe_hazard_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  drs,
    input  logic [4:0]  drt,
    input  logic        duse_rs,
    input  logic        duse_rt,
    input  logic [4:0]  drn,
    input  logic        dwreg,
    input  logic        dm2reg,
    input  logic        dshift,
    input  logic        daluimm,
    input  logic        ex_is_cond,
    input  logic        ex_is_uncond,
    output logic [1:0]  eadepen,
    output logic [1:0]  ebdepen,
    output logic        stall,
    output logic        flush_f,
    output logic        e_bubble,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } state_t;

    localparam logic [1:0] SEL_REG = 2'b00;
    localparam logic [1:0] SEL_IMM = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b11;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_e_valid;
    logic [4:0]  r_e_rn;
    logic        r_e_wreg;
    logic        r_e_m2reg;
    logic        r_m_valid;
    logic [4:0]  r_m_rn;
    logic        r_m_wreg;
    logic        r_m_m2reg;

    logic [1:0]  r_asel;
    logic [1:0]  r_bsel;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    logic        w_e_prod;
    logic        w_m_prod;
    logic        w_e_rs;
    logic        w_e_rt;
    logic        w_m_rs;
    logic        w_m_rt;
    logic        w_lu;
    logic        w_taken;
    logic        w_stall;
    logic        w_flush;
    logic        w_bubble;
    logic [1:0]  w_asel_nxt;
    logic [1:0]  w_bsel_nxt;

    // A slot can only forward if it really writes a non-zero register.
    assign w_e_prod = r_e_valid & r_e_wreg & (r_e_rn != 5'd0);
    assign w_m_prod = r_m_valid & r_m_wreg & (r_m_rn != 5'd0);
    assign w_e_rs   = w_e_prod & (r_e_rn == drs);
    assign w_e_rt   = w_e_prod & (r_e_rn == drt);
    assign w_m_rs   = w_m_prod & (r_m_rn == drs);
    assign w_m_rt   = w_m_prod & (r_m_rn == drt);

    // Load data is not available until WB, so a load in EX feeding ID must stall.
    assign w_lu = r_e_m2reg & ((duse_rs & w_e_rs) | (duse_rt & w_e_rt));

    // Flush FSM next state; the branch outcome only counts in RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_taken     = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_taken = ex_is_cond | ex_is_uncond;
                if (w_taken) begin
                    w_state_nxt = ST_SQUASH;
                end
            end
            ST_SQUASH: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // A taken branch wins over a stall: the ID instruction is wrong-path anyway.
    always_comb begin
        w_stall  = 1'b0;
        w_flush  = 1'b0;
        w_bubble = 1'b0;
        if (!reset) begin
            w_stall  = w_lu & ~w_taken;
            w_flush  = w_taken;
            w_bubble = w_taken | w_lu;
        end
    end

    // Operand select for the instruction leaving ID; the newer producer wins.
    always_comb begin
        w_asel_nxt = SEL_REG;
        w_bsel_nxt = SEL_REG;
        if (dshift) begin
            w_asel_nxt = SEL_IMM;
        end else if (w_e_rs && !r_e_m2reg) begin
            w_asel_nxt = SEL_MEM;
        end else if (w_m_rs) begin
            w_asel_nxt = SEL_WB;
        end
        if (daluimm) begin
            w_bsel_nxt = SEL_IMM;
        end else if (w_e_rt && !r_e_m2reg) begin
            w_bsel_nxt = SEL_MEM;
        end else if (w_m_rt) begin
            w_bsel_nxt = SEL_WB;
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Shadow slots mirroring ID/EX and EX/MEM, plus the registered selects.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_e_valid <= 1'b0;
            r_e_rn    <= 5'd0;
            r_e_wreg  <= 1'b0;
            r_e_m2reg <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_rn    <= 5'd0;
            r_m_wreg  <= 1'b0;
            r_m_m2reg <= 1'b0;
            r_asel    <= SEL_REG;
            r_bsel    <= SEL_REG;
        end else begin
            r_m_valid <= r_e_valid;
            r_m_rn    <= r_e_rn;
            r_m_wreg  <= r_e_wreg;
            r_m_m2reg <= r_e_m2reg;
            if (w_bubble) begin
                r_e_valid <= 1'b0;
                r_e_rn    <= 5'd0;
                r_e_wreg  <= 1'b0;
                r_e_m2reg <= 1'b0;
                r_asel    <= SEL_REG;
                r_bsel    <= SEL_REG;
            end else begin
                r_e_valid <= 1'b1;
                r_e_rn    <= drn;
                r_e_wreg  <= dwreg;
                r_e_m2reg <= dm2reg;
                r_asel    <= w_asel_nxt;
                r_bsel    <= w_bsel_nxt;
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_taken && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign eadepen   = r_asel;
    assign ebdepen   = r_bsel;
    assign stall     = w_stall;
    assign flush_f   = w_flush;
    assign e_bubble  = w_bubble;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios plus randomized traffic,
// all checked against an instruction-level model of the pipeline.
module tb_pipe_hazard_ctrl;

    logic        clock;
    logic        reset;
    logic [4:0]  drs, drt, drn;
    logic        duse_rs, duse_rt, dwreg, dm2reg, dshift, daluimm;
    logic        ex_is_cond, ex_is_uncond;
    logic [1:0]  eadepen, ebdepen;
    logic        stall, flush_f, e_bubble;
    logic [15:0] stall_cnt, flush_cnt;

    int n_total = 0;
    int n_pass  = 0;

    pipe_hazard_ctrl dut (
        .clock(clock), .reset(reset),
        .drs(drs), .drt(drt), .duse_rs(duse_rs), .duse_rt(duse_rt),
        .drn(drn), .dwreg(dwreg), .dm2reg(dm2reg),
        .dshift(dshift), .daluimm(daluimm),
        .ex_is_cond(ex_is_cond), .ex_is_uncond(ex_is_uncond),
        .eadepen(eadepen), .ebdepen(ebdepen),
        .stall(stall), .flush_f(flush_f), .e_bubble(e_bubble),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       v;
        logic [4:0] rn;
        logic       w;
        logic       ld;
    } inst_t;

    inst_t      in_ex, in_mem, nx_ex, nx_mem;
    bit         prev_taken, nx_prev_taken;
    int         m_scnt, m_fcnt, nx_scnt, nx_fcnt;
    logic [1:0] m_asel, m_bsel, nx_asel, nx_bsel;
    logic       exp_stall, exp_flush, exp_bub;

    function automatic bit produces(inst_t i, logic [4:0] src);
        return i.v && i.w && (i.rn != 5'd0) && (i.rn == src);
    endfunction

    function automatic logic [1:0] source_of(inst_t ex, inst_t mem, logic [4:0] src, logic imm);
        if (imm) return 2'b01;
        if (produces(ex, src) && !ex.ld) return 2'b10;
        if (produces(mem, src)) return 2'b11;
        return 2'b00;
    endfunction

    // Settle combinational logic, then derive expected outputs and next model state.
    task automatic eval();
        bit lu, tk;
        #1;
        lu = in_ex.ld && ((duse_rs && produces(in_ex, drs)) || (duse_rt && produces(in_ex, drt)));
        tk = !prev_taken && (ex_is_cond || ex_is_uncond);
        if (reset) begin
            exp_stall = 0; exp_flush = 0; exp_bub = 0;
            nx_ex = '0; nx_mem = '0; nx_prev_taken = 0;
            nx_scnt = 0; nx_fcnt = 0; nx_asel = 2'b00; nx_bsel = 2'b00;
        end else begin
            exp_stall = lu && !tk;
            exp_flush = tk;
            exp_bub   = tk || lu;
            nx_mem = in_ex;
            if (exp_bub) begin
                nx_ex = '0; nx_asel = 2'b00; nx_bsel = 2'b00;
            end else begin
                nx_ex = '{v: 1'b1, rn: drn, w: dwreg, ld: dm2reg};
                nx_asel = source_of(in_ex, in_mem, drs, dshift);
                nx_bsel = source_of(in_ex, in_mem, drt, daluimm);
            end
            nx_prev_taken = tk;
            nx_scnt = (exp_stall && m_scnt < 65535) ? m_scnt + 1 : m_scnt;
            nx_fcnt = (tk && m_fcnt < 65535) ? m_fcnt + 1 : m_fcnt;
        end
    endtask

    task automatic adv();
        @(posedge clock);
        in_ex = nx_ex; in_mem = nx_mem; prev_taken = nx_prev_taken;
        m_scnt = nx_scnt; m_fcnt = nx_fcnt; m_asel = nx_asel; m_bsel = nx_bsel;
        @(negedge clock);
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                          input logic [4:0] rn, input logic wr, input logic ld, input logic sh,
                          input logic im, input logic cnd, input logic unc);
        drs = rs; drt = rt; duse_rs = urs; duse_rt = urt; drn = rn; dwreg = wr;
        dm2reg = ld; dshift = sh; daluimm = im; ex_is_cond = cnd; ex_is_uncond = unc;
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1; nop(); eval(); adv(); reset = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1;
        set_id(7, 7, 1, 1, 7, 1, 1, 0, 0, 1, 1);
        eval();
        n_total++; if ({stall, flush_f, e_bubble} !== 3'b000) $display("FAIL reset_comb got=%b exp=000", {stall, flush_f, e_bubble}); else n_pass++;
        adv();
        reset = 0; nop(); eval();
        n_total++; if ({eadepen, ebdepen} !== 4'b0000) $display("FAIL reset_sel got=%b exp=0000", {eadepen, ebdepen}); else n_pass++;
        n_total++; if ({stall_cnt, flush_cnt} !== 32'd0) $display("FAIL reset_cnt got=%h exp=0", {stall_cnt, flush_cnt}); else n_pass++;
        adv();
    endtask

    task automatic test_alu_alu();
        do_reset();
        set_id(1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0); eval(); adv();
        set_id(3, 4, 1, 1, 8, 1, 0, 0, 0, 0, 0); eval();
        n_total++; if (stall !== 1'b0) $display("FAIL alu_alu_stall got=%b exp=0", stall); else n_pass++;
        adv();
        nop(); eval();
        n_total++; if (eadepen !== 2'b10) $display("FAIL alu_alu_asel got=%b exp=10", eadepen); else n_pass++;
        n_total++; if (ebdepen !== 2'b00) $display("FAIL alu_alu_bsel got=%b exp=00", ebdepen); else n_pass++;
        adv();
    endtask

    task automatic test_dist2_overrides();
        do_reset();
        set_id(1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 0); eval(); adv();
        set_id(1, 2, 1, 1, 9, 1, 0, 0, 0, 0, 0); eval(); adv();
        set_id(6, 5, 1, 1, 10, 1, 0, 0, 0, 0, 0); eval(); adv();
        set_id(1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0); eval();
        n_total++; if (ebdepen !== 2'b11) $display("FAIL dist2_bsel got=%b exp=11", ebdepen); else n_pass++;
        n_total++; if (eadepen !== 2'b00) $display("FAIL dist2_asel got=%b exp=00", eadepen); else n_pass++;
        adv();
        set_id(0, 0, 1, 0, 11, 1, 0, 0, 0, 0, 0); eval(); adv();
        set_id(1, 0, 1, 0, 6, 1, 0, 0, 0, 0, 0); eval();
        n_total++; if (eadepen !== 2'b00) $display("FAIL r0_asel got=%b exp=00", eadepen); else n_pass++;
        adv();
        set_id(6, 0, 1, 0, 12, 1, 0, 1, 0, 0, 0); eval(); adv();
        nop(); eval();
        n_total++; if (eadepen !== 2'b01) $display("FAIL shift_asel got=%b exp=01", eadepen); else n_pass++;
        adv();
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1, 0, 1, 0, 7, 1, 1, 0, 0, 0, 0); eval(); adv();
        set_id(7, 0, 1, 0, 8, 1, 0, 0, 0, 0, 0); eval();
        n_total++; if ({stall, e_bubble, flush_f} !== 3'b110) $display("FAIL lu_first got=%b exp=110", {stall, e_bubble, flush_f}); else n_pass++;
        adv();
        eval();
        n_total++; if ({stall, e_bubble} !== 2'b00) $display("FAIL lu_second got=%b exp=00", {stall, e_bubble}); else n_pass++;
        n_total++; if (stall_cnt !== 16'd1) $display("FAIL lu_cnt got=%0d exp=1", stall_cnt); else n_pass++;
        adv();
        nop(); eval();
        n_total++; if (eadepen !== 2'b11) $display("FAIL lu_asel got=%b exp=11", eadepen); else n_pass++;
        adv();
    endtask

    task automatic test_branch();
        do_reset();
        set_id(1, 2, 1, 1, 4, 1, 0, 0, 0, 1, 0); eval();
        n_total++; if ({flush_f, e_bubble, stall} !== 3'b110) $display("FAIL br_taken got=%b exp=110", {flush_f, e_bubble, stall}); else n_pass++;
        adv();
        eval();
        n_total++; if ({flush_f, e_bubble} !== 2'b00) $display("FAIL br_squash got=%b exp=00", {flush_f, e_bubble}); else n_pass++;
        n_total++; if (flush_cnt !== 16'd1) $display("FAIL br_cnt got=%0d exp=1", flush_cnt); else n_pass++;
        adv();
        set_id(1, 2, 1, 1, 4, 1, 0, 0, 0, 0, 1); eval();
        n_total++; if (flush_f !== 1'b1) $display("FAIL jmp_taken got=%b exp=1", flush_f); else n_pass++;
        adv();
        nop(); eval();
        n_total++; if (flush_cnt !== 16'd2) $display("FAIL jmp_cnt got=%0d exp=2", flush_cnt); else n_pass++;
        adv();
    endtask

    task automatic test_lu_and_taken();
        do_reset();
        set_id(1, 0, 1, 0, 7, 1, 1, 0, 0, 0, 0); eval(); adv();
        set_id(7, 0, 1, 0, 8, 1, 0, 0, 0, 1, 0); eval();
        n_total++; if ({stall, flush_f, e_bubble} !== 3'b011) $display("FAIL lu_tk_comb got=%b exp=011", {stall, flush_f, e_bubble}); else n_pass++;
        adv();
        nop(); eval();
        n_total++; if ({stall_cnt, flush_cnt} !== {16'd0, 16'd1}) $display("FAIL lu_tk_cnt got=%h exp=00000001", {stall_cnt, flush_cnt}); else n_pass++;
        n_total++; if (eadepen !== 2'b00) $display("FAIL lu_tk_asel got=%b exp=00", eadepen); else n_pass++;
        adv();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            set_id(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                   5'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 2) == 0),
                   ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0));
            eval();
            n_total++; if ({stall, flush_f, e_bubble} !== {exp_stall, exp_flush, exp_bub}) $display("FAIL rnd_comb i=%0d got=%b exp=%b", i, {stall, flush_f, e_bubble}, {exp_stall, exp_flush, exp_bub}); else n_pass++;
            n_total++; if ({eadepen, ebdepen} !== {m_asel, m_bsel}) $display("FAIL rnd_sel i=%0d got=%b exp=%b", i, {eadepen, ebdepen}, {m_asel, m_bsel}); else n_pass++;
            n_total++; if ({stall_cnt, flush_cnt} !== {16'(m_scnt), 16'(m_fcnt)}) $display("FAIL rnd_cnt i=%0d got=%h exp=%h", i, {stall_cnt, flush_cnt}, {16'(m_scnt), 16'(m_fcnt)}); else n_pass++;
            adv();
        end
        reset = 0;
    endtask

    task automatic test_saturation_reset();
        do_reset();
        force dut.r_stall_cnt = 16'hFFFE;
        force dut.r_flush_cnt = 16'hFFFE;
        #1;
        release dut.r_stall_cnt;
        release dut.r_flush_cnt;
        m_scnt = 65534; m_fcnt = 65534;
        set_id(1, 0, 1, 0, 7, 1, 1, 0, 0, 0, 0); eval(); adv();
        set_id(7, 0, 1, 0, 8, 1, 0, 0, 0, 0, 0); eval(); adv();
        set_id(1, 0, 1, 0, 7, 1, 1, 0, 0, 0, 0); eval();
        n_total++; if (stall_cnt !== 16'hFFFF) $display("FAIL sat_stall_reach got=%h exp=ffff", stall_cnt); else n_pass++;
        adv();
        set_id(7, 0, 1, 0, 8, 1, 0, 0, 0, 0, 0); eval();
        n_total++; if (stall !== 1'b1) $display("FAIL sat_stall_event got=%b exp=1", stall); else n_pass++;
        adv();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); eval();
        n_total++; if (stall_cnt !== 16'hFFFF) $display("FAIL sat_stall_hold got=%h exp=ffff", stall_cnt); else n_pass++;
        adv();
        nop(); eval();
        n_total++; if (flush_cnt !== 16'hFFFF) $display("FAIL sat_flush_reach got=%h exp=ffff", flush_cnt); else n_pass++;
        adv();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); eval();
        n_total++; if (flush_f !== 1'b1) $display("FAIL sat_flush_event got=%b exp=1", flush_f); else n_pass++;
        adv();
        reset = 1;
        set_id(7, 7, 1, 1, 7, 1, 1, 0, 0, 1, 1); eval();
        n_total++; if (flush_cnt !== 16'hFFFF) $display("FAIL sat_flush_hold got=%h exp=ffff", flush_cnt); else n_pass++;
        n_total++; if ({stall, flush_f, e_bubble} !== 3'b000) $display("FAIL sq_reset_comb got=%b exp=000", {stall, flush_f, e_bubble}); else n_pass++;
        adv();
        reset = 0; nop(); eval();
        n_total++; if ({eadepen, ebdepen, stall, flush_f, e_bubble} !== 7'd0) $display("FAIL post_reset_out got=%b exp=0000000", {eadepen, ebdepen, stall, flush_f, e_bubble}); else n_pass++;
        n_total++; if ({stall_cnt, flush_cnt} !== 32'd0) $display("FAIL post_reset_cnt got=%h exp=0", {stall_cnt, flush_cnt}); else n_pass++;
        adv();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); eval();
        n_total++; if (flush_f !== 1'b1) $display("FAIL post_reset_run got=%b exp=1", flush_f); else n_pass++;
        adv();
    endtask

    initial begin
        clock = 0;
        reset = 1;
        nop();
        in_ex = '0; in_mem = '0; prev_taken = 0;
        m_scnt = 0; m_fcnt = 0; m_asel = 2'b00; m_bsel = 2'b00;
        @(negedge clock);
        test_reset();
        test_alu_alu();
        test_dist2_overrides();
        test_load_use();
        test_branch();
        test_lu_and_taken();
        test_random();
        test_saturation_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and forwarding controller for the five-stage pipeline. Decodes operand dependencies of the instruction in ID and drives the two 2-bit operand selects of the EX-stage ALU input muxes, registered at the ID→EX edge. Consumes the EX-stage branch outcome to squash wrong-path instructions. Inserts load-use stalls and keeps saturating stall and flush counters for performance debug.

## Interface
- No parameters.
- `clock` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `drs`, `drt` in 5: ID-stage source register numbers.
- `duse_rs`, `duse_rt` in 1: ID instruction actually reads rs / rt.
- `drn` in 5: ID destination register (already 31 for jal).
- `dwreg` in 1: ID instruction writes the register file.
- `dm2reg` in 1: ID instruction is a load.
- `dshift`, `daluimm` in 1: ALU A is the shift amount; ALU B is the immediate.
- `ex_is_cond`, `ex_is_uncond` in 1: EX-stage branch taken / jump taken.
- `eadepen`, `ebdepen` out 2: EX operand selects.
  - 00: register file value.
  - 01: shift amount / immediate.
  - 10: MEM-stage ALU result.
  - 11: WB write data.
- `stall` out 1: hold PC and the IF/ID register.
- `flush_f` out 1: load a nop into IF/ID.
- `e_bubble` out 1: load a nop into ID/EX.
- `stall_cnt`, `flush_cnt` out 16: saturating event counters.

## Operation
- Internal shadow slots E and M each hold {valid, rn, wreg, m2reg} and mirror the ID/EX and EX/MEM registers.
- Each edge:
  - M ← E.
  - E ← ID info, or invalid when `e_bubble`=1.
- Match condition: A slot matches a source when it is valid, has wreg=1, rn≠0, and rn equals the source.
- Load-use condition: `lu` = E.m2reg, and E matches an ID source whose use bit is 1.
- Taken condition: `taken` = `ex_is_cond` | `ex_is_uncond`.
- Output equations (combinational):
  - `stall` = `lu` & ~`taken`.
  - `flush_f` = `taken`.
  - `e_bubble` = `taken` | `lu`.
  - A taken branch overrides a stall, because the ID instruction is wrong-path.
- Next-select computation for A (B is identical with rt and `daluimm`):
  - `dshift`=1 → 01.
  - Otherwise E matches rs (not a load) → 10.
  - Otherwise M matches rs → 11.
  - Otherwise → 00.
  - The newer producer (slot E) wins over slot M.
- On `e_bubble`, the registered selects load 00.
- Flush FSM, states RUN and SQUASH:
  - RUN → SQUASH on `taken`.
  - SQUASH → RUN unconditionally after one cycle.
  - In SQUASH, `ex_is_*` are ignored: the EX instruction is the bubble just inserted, so `taken` is forced to 0.
- Counters:
  - `stall_cnt` increments on each cycle with `stall`=1.
  - `flush_cnt` increments on each RUN→SQUASH transition.
  - Both saturate at 16'hFFFF.
- `reset` has priority over everything:
  - Slots invalid, selects 00, FSM RUN, counters 0.
  - `stall`, `flush_f`, `e_bubble` are 0 in the reset cycle.

## Timing
- `eadepen`/`ebdepen` are registered. They change on the edge where the instruction enters EX and are valid for its entire EX cycle.
- `stall`, `flush_f`, `e_bubble` are combinational from current inputs and slot state, with no added latency.
- Load-use costs exactly 1 stall cycle. The consumer then sees select 11, taking the load data from WB.
- A taken branch in EX costs 2 killed instructions: ID (via `e_bubble`) and IF (via `flush_f`).
- Reset asserted mid-stall or mid-SQUASH clears the condition on that edge; the next cycle is RUN with empty slots.

## Test plan
- ALU-ALU back-to-back:
  - Stimulus: add r3 (drn=3, dwreg=1), then sub reading drs=3.
  - Required: `eadepen`=10 in sub's EX cycle; `stall`=0.
- Distance-2 dependency, plus $0 and shift/immediate overrides:
  - Distance 2, producer r5 then consumer drt=5 → `ebdepen`=11.
  - Consumer drs=0 with a producer of rn=0 → `eadepen`=00.
  - Same dependency with `dshift`=1 → `eadepen`=01.
- Load-use:
  - Stimulus: lw r7 (dm2reg=1) immediately followed by drs=7.
  - Required: `stall`=1 and `e_bubble`=1 for exactly 1 cycle; then `eadepen`=11; `stall_cnt`=1.
- Branch taken:
  - Stimulus: `ex_is_cond`=1 for 1 cycle.
  - Required: `flush_f`=1 and `e_bubble`=1 that cycle.
  - Next cycle, `ex_is_cond`=1 is ignored (SQUASH); `flush_cnt`=1.
- Simultaneous load-use and taken:
  - Required: `stall`=0, `flush_f`=1, `e_bubble`=1; `stall_cnt` unchanged.
- Reset and counter saturation:
  - Stimulus: `reset` asserted during SQUASH with counters at 16'hFFFF.
  - Required before reset: counters hold at FFFF on further events.
  - Required after reset: all outputs 0, selects 00.
